// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   state_t / St*  : FSM state encoding (IDLE, REQ, RESP, DONE)
//   SZ_*           : access size encodings on req_size
//   STRB_W         : width of the memory write strobe
//   is_misaligned  : alignment rule for a given size and low address bits
package lsu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StReq  = 2'd1;
  localparam state_t StResp = 2'd2;
  localparam state_t StDone = 2'd3;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  localparam int unsigned STRB_W = 4;

  // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the load/store unit.
// Store side: builds the lane-replicated write data and byte strobe from the
//   access size, low address bits and raw store data.
// Load side: shifts the read word down to the addressed byte, keeps 8/16/32
//   bits and zero- or sign-extends the result.
// Ports:
//   st_size, st_addr_lo, st_data -> st_wstrb, st_wdata
//   ld_size, ld_addr_lo, ld_unsigned, rdata -> ld_data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic [1:0]          st_size,
  input  logic [1:0]          st_addr_lo,
  input  logic [DATA_LEN-1:0] st_data,
  output logic [STRB_W-1:0]   st_wstrb,
  output logic [DATA_LEN-1:0] st_wdata,
  input  logic [1:0]          ld_size,
  input  logic [1:0]          ld_addr_lo,
  input  logic                ld_unsigned,
  input  logic [DATA_LEN-1:0] rdata,
  output logic [DATA_LEN-1:0] ld_data
);

  logic [DATA_LEN-1:0] shifted;

  always_comb begin
    st_wstrb = '0;
    st_wdata = '0;
    case (st_size)
      SZ_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_addr_lo;
      end
      SZ_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << st_addr_lo;
      end
      SZ_W: begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = '0;
        st_wstrb = '0;
      end
    endcase
  end

  always_comb begin
    shifted = rdata >> {ld_addr_lo, 3'b000};
    ld_data = shifted;
    case (ld_size)
      SZ_B: ld_data = ld_unsigned ? {{(DATA_LEN-8){1'b0}}, shifted[7:0]}
                                  : {{(DATA_LEN-8){shifted[7]}}, shifted[7:0]};
      SZ_H: ld_data = ld_unsigned ? {{(DATA_LEN-16){1'b0}}, shifted[15:0]}
                                  : {{(DATA_LEN-16){shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit sitting behind exu. Latches one load or store request,
// runs it over a valid/ready memory bus and pulses done when finished.
// lsu_busy is high for the whole access so ifu can hold the PC.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_*                           request from exu (held until done)
//   lsu_busy, done, load_data,
//   misalign_err                    status / result back to the core
//   mem_req_*                       bus request channel (valid/ready)
//   mem_resp_*                      bus response channel (valid/ready)
// Every output is a register or a decode of the state register, so no bus
// input reaches a bus output combinationally.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [DATA_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                lsu_busy,
  output logic                done,
  output logic [DATA_LEN-1:0] load_data,
  output logic                misalign_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [DATA_LEN-1:0] mem_req_addr,
  output logic                mem_req_wen,
  output logic [STRB_W-1:0]   mem_req_wstrb,
  output logic [DATA_LEN-1:0] mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_resp_rdata,
  output logic                mem_resp_ready
);

  state_t state_q, state_d;

  // Latched request qualifiers; the live req_* inputs are not trusted after
  // acceptance.
  logic       is_load_q;
  logic       uns_q;
  logic [1:0] size_q;
  logic [1:0] addr_lo_q;

  logic                is_req;
  logic                req_err;
  logic [STRB_W-1:0]   st_wstrb;
  logic [DATA_LEN-1:0] st_wdata;
  logic [DATA_LEN-1:0] ld_data;

  assign is_req  = (state_q == StIdle) && req_valid && (req_load || req_store);
  assign req_err = (req_load && req_store) || (req_size == SZ_ILL) ||
                   is_misaligned(req_size, req_addr[1:0]);

  lsu_align #(
    .DATA_LEN (DATA_LEN)
  ) u_align (
    .st_size     (req_size),
    .st_addr_lo  (req_addr[1:0]),
    .st_data     (req_wdata),
    .st_wstrb    (st_wstrb),
    .st_wdata    (st_wdata),
    .ld_size     (size_q),
    .ld_addr_lo  (addr_lo_q),
    .ld_unsigned (uns_q),
    .rdata       (mem_resp_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (is_req) state_d = req_err ? StDone : StReq;
      StReq:   if (mem_req_ready) state_d = StResp;
      StResp:  if (mem_resp_valid) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      is_load_q     <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= SZ_B;
      addr_lo_q     <= 2'b00;
      load_data     <= '0;
      misalign_err  <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wstrb <= '0;
      mem_req_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (is_req) begin
        is_load_q <= req_load;
        uns_q     <= req_unsigned;
        size_q    <= req_size;
        addr_lo_q <= req_addr[1:0];
        if (req_err) begin
          load_data    <= '0;
          misalign_err <= 1'b1;
        end else begin
          misalign_err  <= 1'b0;
          mem_req_addr  <= {req_addr[DATA_LEN-1:2], 2'b00};
          mem_req_wen   <= req_store;
          mem_req_wstrb <= req_store ? st_wstrb : '0;
          mem_req_wdata <= req_store ? st_wdata : '0;
        end
      end
      if ((state_q == StResp) && mem_resp_valid) begin
        // Stores complete through here too; their result is defined as zero.
        load_data <= is_load_q ? ld_data : '0;
      end
      if (state_q == StDone) begin
        misalign_err  <= 1'b0;
        mem_req_addr  <= '0;
        mem_req_wen   <= 1'b0;
        mem_req_wstrb <= '0;
        mem_req_wdata <= '0;
      end
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign lsu_busy       = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign mem_req_valid  = (state_q == StReq);
  assign mem_resp_ready = (state_q == StResp);

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        lsu_busy;
  logic        done;
  logic [31:0] load_data;
  logic        misalign_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_ready;

  int errors = 0;
  int checks = 0;

  lsu #(.DATA_LEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_load       (req_load),
    .req_store      (req_store),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .lsu_busy       (lsu_busy),
    .done           (done),
    .load_data      (load_data),
    .misalign_err   (misalign_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_resp_ready (mem_resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the last access.
  int          lat;
  int          gap;
  logic [31:0] ldat;
  logic        merr;
  logic        saw_req;
  logic [31:0] c_addr;
  logic        c_wen;
  logic [3:0]  c_strb;
  logic [31:0] c_wdata;
  logic        stable;
  logic        busy_ok;

  // Runs one access. Called at a negedge; inputs change at negedges only and
  // outputs are sampled at negedges. lat counts posedges after the accepting
  // edge until done is seen (-1 on timeout). req_ready is held low for
  // wait_cyc REQ cycles; mem_resp_valid is high throughout, so a response
  // during REQ must be ignored.
  task automatic do_access(input logic ld, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int wait_cyc);
    int waits;
    gap = 0;
    while (!req_ready && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; mem_resp_rdata = rd;
    mem_req_ready = (wait_cyc == 0); mem_resp_valid = 1'b1;
    lat = -1; saw_req = 1'b0; stable = 1'b1; busy_ok = 1'b1; waits = 0;
    ldat = 'x; merr = 1'bx; c_addr = '0; c_wen = 1'b0; c_strb = '0; c_wdata = '0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!lsu_busy) busy_ok = 1'b0;
      if (mem_req_valid) begin
        if (!saw_req) begin
          c_addr = mem_req_addr; c_wen = mem_req_wen;
          c_strb = mem_req_wstrb; c_wdata = mem_req_wdata;
        end else if (c_addr !== mem_req_addr || c_wen !== mem_req_wen ||
                     c_strb !== mem_req_wstrb || c_wdata !== mem_req_wdata) begin
          stable = 1'b0;
        end
        saw_req = 1'b1;
        if (waits == wait_cyc) mem_req_ready = 1'b1;
        else begin
          mem_req_ready = 1'b0;
          waits++;
        end
      end
      if (done) begin
        lat = n; ldat = load_data; merr = misalign_err;
        break;
      end
    end
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    #2;
    checks++;
    if ({req_ready, lsu_busy, done, misalign_err, mem_req_valid, mem_resp_ready, mem_req_wen}
        !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1000000", {req_ready, lsu_busy, done,
               misalign_err, mem_req_valid, mem_resp_ready, mem_req_wen});
    end
    checks++;
    if ({load_data, mem_req_addr, mem_req_wdata, mem_req_wstrb} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data: got ld=%h addr=%h wd=%h strb=%b want all zero",
               load_data, mem_req_addr, mem_req_wdata, mem_req_wstrb);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_load();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678, 0);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL word_load latency: got %0d want 3", lat); end
    checks++;
    if (ldat !== 32'h1234_5678) begin
      errors++; $display("FAIL word_load data: got %h want 12345678", ldat);
    end
    checks++;
    if ({saw_req, c_addr, c_wen, c_strb, merr} !== {1'b1, 32'h8000_0004, 1'b0, 4'b0000, 1'b0})
    begin
      errors++;
      $display("FAIL word_load bus: got req=%b addr=%h wen=%b strb=%b err=%b want 1 80000004 0 0000 0",
               saw_req, c_addr, c_wen, c_strb, merr);
    end
  endtask

  task automatic test_byte_load();
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 0);
    checks++;
    if (ldat !== 32'hFFFF_FF80 || lat !== 3) begin
      errors++; $display("FAIL byte_load_signed: got %h lat %0d want ffffff80 lat 3", ldat, lat);
    end
    checks++;
    if (c_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL byte_load_addr: got %h want 80000000", c_addr);
    end
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 0);
    checks++;
    if (ldat !== 32'h0000_0080) begin
      errors++; $display("FAIL byte_load_unsigned: got %h want 00000080", ldat);
    end
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0, 32'h9234_0000, 0);
    checks++;
    if (ldat !== 32'hFFFF_9234) begin
      errors++; $display("FAIL half_load_signed: got %h want ffff9234", ldat);
    end
  endtask

  task automatic test_half_store();
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 0);
    checks++;
    if ({c_wdata, c_strb, c_wen} !== {32'hBEEF_BEEF, 4'b1100, 1'b1}) begin
      errors++;
      $display("FAIL half_store bus: got wd=%h strb=%b wen=%b want beefbeef 1100 1",
               c_wdata, c_strb, c_wen);
    end
    checks++;
    if (lat !== 3 || merr !== 1'b0) begin
      errors++; $display("FAIL half_store done: got lat %0d err %b want 3 0", lat, merr);
    end
  endtask

  task automatic test_misalign();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0006, 32'h0, 32'hDEAD_BEEF, 0);
    checks++;
    if ({lat, merr, saw_req, ldat} !== {32'd1, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL word_misalign: got lat %0d err %b req %b ld %h want 1 1 0 0",
               lat, merr, saw_req, ldat);
    end
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h8000_0001, 32'h1234, 32'h0, 0);
    checks++;
    if ({lat, merr, saw_req} !== {32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL half_misalign: got lat %0d err %b req %b want 1 1 0", lat, merr, saw_req);
    end
    do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0);
    checks++;
    if ({lat, merr, saw_req} !== {32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL illegal_both: got lat %0d err %b req %b want 1 1 0", lat, merr, saw_req);
    end
    do_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0);
    checks++;
    if ({lat, merr, saw_req} !== {32'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL illegal_size: got lat %0d err %b req %b want 1 1 0", lat, merr, saw_req);
    end
  endtask

  task automatic test_ignored();
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b0; req_size = 2'b10;
    req_addr = 32'h8000_0000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, lsu_busy, mem_req_valid} !== 3'b100) begin
      errors++;
      $display("FAIL no_op_ignored: got ready/busy/req %b want 100",
               {req_ready, lsu_busy, mem_req_valid});
    end
    req_valid = 1'b0;
  endtask

  task automatic test_wait_states();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 3);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL wait_latency: got %0d want 6", lat); end
    checks++;
    if ({stable, busy_ok} !== 2'b11) begin
      errors++; $display("FAIL wait_stable_busy: got %b want 11", {stable, busy_ok});
    end
    checks++;
    if (ldat !== 32'hCAFE_F00D || c_addr !== 32'h8000_0008) begin
      errors++; $display("FAIL wait_data: got %h @%h want cafef00d @80000008", ldat, c_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h8000_0001, 32'h0000_00A5, 32'h0, 0);
    checks++;
    if ({c_wdata, c_strb, lat} !== {32'hA5A5_A5A5, 4'b0010, 32'd3}) begin
      errors++;
      $display("FAIL b2b_first: got wd=%h strb=%b lat %0d want a5a5a5a5 0010 3",
               c_wdata, c_strb, lat);
    end
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h8000_0002, 32'h0, 32'h8001_0000, 0);
    checks++;
    if (gap !== 1) begin errors++; $display("FAIL b2b_gap: got %0d want 1", gap); end
    checks++;
    if (ldat !== 32'h0000_8001 || lat !== 3) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d want 00008001 lat 3", ldat, lat);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h8000_0010; req_wdata = 32'h1122_3344;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_resp_ready, mem_req_wen, mem_req_wstrb} !== 6'b111111) begin
      errors++;
      $display("FAIL mid_reset_in_resp: got rr/wen/strb %b want 111111",
               {mem_resp_ready, mem_req_wen, mem_req_wstrb});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, lsu_busy, done, misalign_err, mem_req_valid, mem_resp_ready, mem_req_wen}
        !== 7'b1000000 ||
        {load_data, mem_req_addr, mem_req_wdata, mem_req_wstrb} !== 100'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got ctrl=%b ld=%h addr=%h wd=%h strb=%b want 1000000 and zeros",
               {req_ready, lsu_busy, done, misalign_err, mem_req_valid, mem_resp_ready,
                mem_req_wen}, load_data, mem_req_addr, mem_req_wdata, mem_req_wstrb);
    end
    req_valid = 1'b0; req_store = 1'b0; mem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h8000_0001, 32'h0, 32'h0000_7F00, 0);
    checks++;
    if (ldat !== 32'h0000_007F || lat !== 3 || c_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL after_reset_load: got %h lat %0d @%h want 0000007f lat 3 @80000000",
               ldat, lat, c_addr);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_ignored();
    test_wait_states();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit placed downstream of `exu`. It takes the effective address and store data, plus the load/store qualifiers, and runs the access over a valid/ready memory bus. The access is multi-cycle. It replaces the single-cycle DPI load/store path in `monitor`, and it holds `lsu_busy` so that `ifu` stalls PC update until the access completes.

## Interface
- `DATA_LEN`, default 32: datapath width. 32 is the only supported value; the strobe is `DATA_LEN/8` = 4 bits.

- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  exu requests an access; held stable until `done`
- `req_ready`  out  1  high only in IDLE
- `req_load`  in  1  access is a load
- `req_store`  in  1  access is a store
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  zero-extend load result
- `req_addr`  in  DATA_LEN  byte address (`dest_data` from exu)
- `req_wdata`  in  DATA_LEN  store data (`src2`)
- `lsu_busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `load_data`  out  DATA_LEN  extended load result, valid with `done`
- `misalign_err`  out  1  valid with `done`
- `mem_req_valid`  out  1  bus request
- `mem_req_ready`  in  1  bus accepts request
- `mem_req_addr`  out  DATA_LEN  word-aligned address (`[1:0]`=0)
- `mem_req_wen`  out  1  1 = write
- `mem_req_wstrb`  out  4  byte enables; 0 for reads
- `mem_req_wdata`  out  DATA_LEN  lane-replicated store data
- `mem_resp_valid`  in  1  read data or write acknowledge
- `mem_resp_rdata`  in  DATA_LEN  read data
- `mem_resp_ready`  out  1  high only in RESP

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - When `req_valid` is high and exactly one of load/store is set, latch all request fields.
  - If the access is aligned, go to REQ; otherwise go to DONE with error.
  - Illegal requests also go to DONE with error and issue no bus traffic: both load and store set, or size 11.
  - `req_valid` with neither load nor store set is ignored.
- REQ: hold `mem_req_valid` and all request fields stable until `mem_req_ready`, then go to RESP.
- RESP: hold `mem_resp_ready` high. On `mem_resp_valid`, go to DONE and register the extended read data (loads). Stores also wait for the response, which acts as the write acknowledge.
- DONE: pulse `done` for one cycle, then return to IDLE.
- Alignment rules:
  - Half is misaligned when `addr[0]`=1.
  - Word is misaligned when `addr[1:0]`≠0.
  - On error: `load_data`=0, `misalign_err`=1, and no bus activity.
- Store lanes:
  - byte: `wdata`={4{d[7:0]}}, `wstrb`=0001<<addr[1:0]
  - half: `wdata`={2{d[15:0]}}, `wstrb`=0011<<addr[1:0]
  - word: `wdata`=d, `wstrb`=1111
- Load extraction: shift `rdata` right by 8·addr[1:0], take the low 8/16/32 bits, then zero- or sign-extend according to `req_unsigned`.
- `req_valid` while not in IDLE is ignored; exu holds the request and the latched copy is authoritative.

## Timing
- Reset values:
  - state = IDLE
  - `done`, `misalign_err`, `mem_req_valid`, `mem_resp_ready`, `mem_req_wen` = 0
  - `mem_req_wstrb` = 0
  - `load_data`, `mem_req_addr`, `mem_req_wdata` = 0
  - `req_ready` = 1, `lsu_busy` = 0
- All outputs are registered or decoded from state only. There is no combinational path from a bus input to a bus output.
- Minimum latency with ready/resp both immediate: `req_valid` accepted at cycle 0, `mem_req_valid` at cycle 1, response at cycle 2, `done` at cycle 3.
- A misaligned or illegal request gives `done` at cycle 1.
- Back-to-back: a new request can be accepted on the cycle after `done`.
- Each bus wait-state cycle adds exactly one cycle to the latency.
- A response arriving in REQ is ignored, because a response is only legal after acceptance.
- Reset asserted mid-access returns the FSM to IDLE immediately. An outstanding bus transaction is abandoned; the bus model must drop it.

## Structure
- Package `lsu_pkg` holds:
  - the state enum
  - size constants (`SZ_B`, `SZ_H`, `SZ_W`)
  - the width of `wstrb`
- Sub-module `lsu_align` is purely combinational. It produces `wstrb`/`wdata` from size/addr/data and load extraction/extension from size/addr/unsigned/rdata.
- `lsu` itself contains the FSM, request latches and bus registers.
- Integration into `top`:
  - `lsu_busy` gates the PC write in `ifu`.
  - `load_data` muxes into the rd write-back when `done` and load.

## Test plan
- Word load at 0x8000_0004, rdata 0x1234_5678, bus ready immediately → `mem_req_addr` 0x8000_0004, `wstrb` 0, `done` at cycle 3, `load_data` 0x1234_5678.
- Signed byte load at 0x8000_0003, rdata 0x80AA_BBCC → `load_data` 0xFFFF_FF80; the unsigned variant gives 0x0000_0080.
- Half store of 0x0000_BEEF at 0x8000_0002 → `wdata` 0xBEEF_BEEF, `wstrb` 1100, `wen` 1, `done` one cycle after the write acknowledge.
- Word load at 0x8000_0006 → `done` at cycle 1, `misalign_err` 1, `mem_req_valid` never asserted.
- `mem_req_ready` held low for 3 cycles → request fields stable throughout, `done` delayed exactly 3 cycles, `lsu_busy` high throughout.
- Reset pulsed while in RESP → state IDLE, all outputs at reset values. A following byte load at 0x8000_0001 with rdata 0x0000_7F00 completes correctly with `load_data` 0x0000_007F.
